// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a pending-write scoreboard.
// Register 0 reads as zero and is never busy. Reads are combinational, with an
// optional same-cycle forward of write data. Busy bits mark registers whose
// producer has been issued but has not yet written back.

// One read port: stored/forwarded data select plus busy lookup.
module regfile_mp_rd_port #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NWRITE = 1,
   parameter int BYPASS = 1,
   parameter int AW     = 5
) (
   input  logic                         rst_n,
   input  logic [AW-1:0]                addr,
   input  logic [NREGS-1:0][XLEN-1:0]   regs,
   input  logic [NREGS-1:0]             busy,
   input  logic [NWRITE-1:0]            wr_en,
   input  logic [NWRITE-1:0][AW-1:0]    wr_addr,
   input  logic [NWRITE-1:0][XLEN-1:0]  wr_data,
   input  logic                         sb_set,
   input  logic [AW-1:0]                sb_addr,
   output logic [XLEN-1:0]              data,
   output logic                         pend
);

   logic            hit;
   logic [XLEN-1:0] fwd;

   // Highest-index enabled write to the same nonzero register is forwarded.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      if (BYPASS != 0) begin
         for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && (wr_addr[j] == addr) && (addr != '0)) begin
               hit = 1'b1;
               fwd = wr_data[j];
            end
         end
      end
   end

   // Select data/busy; a forwarded write retires the pending producer unless
   // a new producer is being issued to the same register this cycle. Reset
   // gates everything so the bypass cannot leak data while rst_n is low.
   always_comb begin
      data = regs[addr];
      pend = busy[addr];
      if (hit) begin
         data = fwd;
         if (!(sb_set && (sb_addr == addr)))
            pend = 1'b0;
      end
      if (!rst_n) begin
         data = '0;
         pend = 1'b0;
      end
   end

endmodule

module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREAD*AW-1:0]      rd_addr,
   output logic [NREAD*XLEN-1:0]    rd_data,
   output logic [NREAD-1:0]         rd_busy,
   input  logic [NWRITE-1:0]        wr_en,
   input  logic [NWRITE*AW-1:0]     wr_addr,
   input  logic [NWRITE*XLEN-1:0]   wr_data,
   input  logic                     sb_set,
   input  logic [AW-1:0]            sb_addr,
   output logic [NREGS-1:0]         busy_vec
);

   // Packed per-port views of the flat port vectors.
   logic [NREAD-1:0][AW-1:0]     ra;
   logic [NREAD-1:0][XLEN-1:0]   rdat;
   logic [NWRITE-1:0][AW-1:0]    wa;
   logic [NWRITE-1:0][XLEN-1:0]  wd;

   assign ra      = rd_addr;
   assign wa      = wr_addr;
   assign wd      = wr_data;
   assign rd_data = rdat;

   logic [NREGS-1:0][XLEN-1:0] regs;
   logic [NREGS-1:0]           busy;
   logic [NREGS-1:0]           clr;

   // Register array; entry 0 is never written so it stays at its reset zero.
   // Ports are walked in ascending order so the highest index wins a collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else begin
         for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && (wa[j] != '0))
               regs[wa[j]] <= wd[j];
         end
      end
   end

   // Registers being written back this cycle (candidates for busy clear).
   always_comb begin
      clr = '0;
      for (int j = 0; j < NWRITE; j++) begin
         if (wr_en[j])
            clr[wa[j]] = 1'b1;
      end
   end

   // Scoreboard: a new producer (set) takes priority over a write-back (clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy[0] <= 1'b0;
         for (int r = 1; r < NREGS; r++) begin
            if (sb_set && (sb_addr == AW'(r)))
               busy[r] <= 1'b1;
            else if (clr[r])
               busy[r] <= 1'b0;
         end
      end
   end

   assign busy_vec = busy;

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      regfile_mp_rd_port #(
         .XLEN   (XLEN),
         .NREGS  (NREGS),
         .NWRITE (NWRITE),
         .BYPASS (BYPASS),
         .AW     (AW)
      ) u_port (
         .rst_n   (rst_n),
         .addr    (ra[i]),
         .regs    (regs),
         .busy    (busy),
         .wr_en   (wr_en),
         .wr_addr (wa),
         .wr_data (wd),
         .sb_set  (sb_set),
         .sb_addr (sb_addr),
         .data    (rdat[i]),
         .pend    (rd_busy[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on / off) driven in parallel.
// Directed table for the listed corner cases, a hand-written async-reset
// sequence, then random traffic against an array-based reference model.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [9:0]    rd_addr;
   logic [1:0]    wr_en;
   logic [9:0]    wr_addr;
   logic [63:0]   wr_data;
   logic          sb_set;
   logic [4:0]    sb_addr;
   logic [63:0]   rd_data_b1, rd_data_b0;
   logic [1:0]    rd_busy_b1, rd_busy_b0;
   logic [31:0]   busy_vec_b1, busy_vec_b0;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .NWRITE(2), .BYPASS(1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
      .busy_vec(busy_vec_b1));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .NWRITE(2), .BYPASS(0)) dut_b0 (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
      .busy_vec(busy_vec_b0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0;
   endtask

   // Register-file semantics applied at a rising edge.
   task automatic model_edge();
      logic [31:0] nb;
      if (!rst_n) begin
         model_clear();
         return;
      end
      nb = m_busy;
      for (int r = 1; r < 32; r++) begin
         logic written;
         written = 1'b0;
         for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] == 5'(r)) written = 1'b1;
         if (sb_set && sb_addr == 5'(r)) nb[r] = 1'b1;
         else if (written) nb[r] = 1'b0;
      end
      for (int j = 0; j < 2; j++)
         if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0)
            m_regs[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
      m_busy = nb;
   endtask

   // Expected read data: stored value, or youngest same-cycle write if bypassing.
   function automatic logic [31:0] exp_data(input int p, input bit byp);
      logic [4:0]  a;
      logic [31:0] d;
      a = rd_addr[p*5 +: 5];
      if (!rst_n) return '0;
      d = m_regs[a];
      if (byp && a != 5'd0)
         for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) d = wr_data[j*32 +: 32];
      return d;
   endfunction

   function automatic logic exp_busy(input int p, input bit byp);
      logic [4:0] a;
      logic       hit;
      a = rd_addr[p*5 +: 5];
      if (!rst_n) return 1'b0;
      hit = 1'b0;
      if (byp && a != 5'd0)
         for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) hit = 1'b1;
      if (hit && !(sb_set && sb_addr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic check_model();
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("m_rd_data_b1[%0d]", p), rd_data_b1[p*32 +: 32], exp_data(p, 1'b1));
         chk($sformatf("m_rd_data_b0[%0d]", p), rd_data_b0[p*32 +: 32], exp_data(p, 1'b0));
         chk($sformatf("m_rd_busy_b1[%0d]", p), 32'(rd_busy_b1[p]), 32'(exp_busy(p, 1'b1)));
         chk($sformatf("m_rd_busy_b0[%0d]", p), 32'(rd_busy_b0[p]), 32'(exp_busy(p, 1'b0)));
      end
      chk("m_busy_vec_b1", busy_vec_b1, rst_n ? m_busy : 32'd0);
      chk("m_busy_vec_b0", busy_vec_b0, rst_n ? m_busy : 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic        sb;
      logic [4:0]  sba;
      logic [4:0]  ra0, ra1;
      logic [31:0] d0_b1, d0_b0, d1_b1, d1_b0;
      logic        bz0_b1, bz0_b0;
      logic [31:0] bvec;
   } vec_t;

   vec_t tbl [17];

   initial begin
      // rst we  wa0 wa1 wd0           wd1 sb sba ra0 ra1 d0_b1         d0_b0         d1_b1         d1_b0         bz1 bz0 bvec
      tbl[0]  = '{0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 1, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 2'b01, 0, 0, 32'h1234, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 2'b01, 7, 0, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0};
      tbl[4]  = '{1, 2'b01, 3, 0, 32'h11, 0, 0, 0, 7, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11, 0, 0, 0, 0};
      tbl[5]  = '{1, 2'b01, 3, 0, 32'h55, 0, 0, 0, 3, 3, 32'h55, 32'h11, 32'h55, 32'h11, 0, 0, 0};
      tbl[6]  = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, 0};
      tbl[7]  = '{1, 2'b11, 9, 9, 32'h1, 32'h2, 0, 0, 9, 9, 32'h2, 0, 32'h2, 0, 0, 0, 0};
      tbl[8]  = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h2, 32'h2, 32'h2, 32'h2, 0, 0, 0};
      tbl[9]  = '{1, 2'b00, 0, 0, 0, 0, 1, 4, 4, 9, 0, 0, 32'h2, 32'h2, 0, 0, 0};
      tbl[10] = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 4, 9, 0, 0, 32'h2, 32'h2, 1, 1, 32'h10};
      tbl[11] = '{1, 2'b01, 4, 0, 32'h44, 0, 0, 0, 4, 4, 32'h44, 0, 32'h44, 0, 0, 1, 32'h10};
      tbl[12] = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 32'h44, 32'h44, 32'h44, 32'h44, 0, 0, 0};
      tbl[13] = '{1, 2'b01, 4, 0, 32'h4444, 0, 1, 4, 4, 4, 32'h4444, 32'h44, 32'h4444, 32'h44, 0, 0, 0};
      tbl[14] = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 32'h4444, 32'h4444, 32'h4444, 32'h4444, 1, 1, 32'h10};
      tbl[15] = '{1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4, 0, 0, 32'h4444, 32'h4444, 0, 0, 32'h10};
      tbl[16] = '{1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 32'h4444, 32'h4444, 0, 0, 32'h10};

      model_clear();

      // Directed table: inputs applied after an edge, checked before the next.
      for (int i = 0; i < 17; i++) begin
         rst_n   = tbl[i].rst;
         wr_en   = tbl[i].we;
         wr_addr = {tbl[i].wa1, tbl[i].wa0};
         wr_data = {tbl[i].wd1, tbl[i].wd0};
         sb_set  = tbl[i].sb;
         sb_addr = tbl[i].sba;
         rd_addr = {tbl[i].ra1, tbl[i].ra0};
         #3;
         chk($sformatf("t%0d_d0_b1", i), rd_data_b1[31:0], tbl[i].d0_b1);
         chk($sformatf("t%0d_d0_b0", i), rd_data_b0[31:0], tbl[i].d0_b0);
         chk($sformatf("t%0d_d1_b1", i), rd_data_b1[63:32], tbl[i].d1_b1);
         chk($sformatf("t%0d_d1_b0", i), rd_data_b0[63:32], tbl[i].d1_b0);
         chk($sformatf("t%0d_bz0_b1", i), 32'(rd_busy_b1[0]), 32'(tbl[i].bz0_b1));
         chk($sformatf("t%0d_bz0_b0", i), 32'(rd_busy_b0[0]), 32'(tbl[i].bz0_b0));
         chk($sformatf("t%0d_bvec_b1", i), busy_vec_b1, tbl[i].bvec);
         chk($sformatf("t%0d_bvec_b0", i), busy_vec_b0, tbl[i].bvec);
         step();
      end

      // Async reset mid-operation: populate registers and busy bits first.
      wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hBBBB, 32'hAAAA};
      sb_set = 1'b1; sb_addr = 5'd6; rd_addr = {5'd6, 5'd10};
      #3; check_model(); step();
      wr_en = 2'b00; sb_set = 1'b1; sb_addr = 5'd8;
      #3; check_model(); step();
      sb_set = 1'b0; rd_addr = {5'd6, 5'd11};
      #3; check_model();
      chk("pre_rst_d1", rd_data_b0[31:0], 32'hBBBB);
      chk("pre_rst_bvec", busy_vec_b0, 32'h0000_0150);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_d0_b1", rd_data_b1[31:0], 32'd0);
      chk("async_d0_b0", rd_data_b0[31:0], 32'd0);
      chk("async_bz1_b1", 32'(rd_busy_b1[1]), 32'd0);
      chk("async_bvec_b1", busy_vec_b1, 32'd0);
      chk("async_bvec_b0", busy_vec_b0, 32'd0);
      model_clear();
      step();
      rst_n = 1'b1;
      #3; check_model(); step();

      // Random traffic on a narrowed address range to force collisions.
      for (int c = 0; c < 600; c++) begin
         logic [4:0] a [6];
         for (int k = 0; k < 6; k++)
            a[k] = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         rst_n   = ($urandom_range(0, 49) != 0);
         wr_en   = 2'($urandom_range(0, 3));
         wr_addr = {a[1], a[0]};
         wr_data = {32'($urandom), 32'($urandom)};
         sb_set  = ($urandom_range(0, 2) == 0);
         sb_addr = a[2];
         rd_addr = ($urandom_range(0, 1) != 0) ? {a[3], a[0]} : {a[4], a[5]};
         if (!rst_n) model_clear();
         #3;
         check_model();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
